// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-word frames.
// Hits are served combinationally (ihit/imemload); a miss issues a single
// word read on iREN/iaddr, fills the frame, then the fetch hits next cycle.
// Ports:
//   CLK, nRST             clock (rising edge), async active-low reset
//   imemREN, imemaddr     datapath fetch request and byte address
//   ihit, imemload        fetch served this cycle and its instruction word
//   iREN, iaddr           memory read request and word-aligned address
//   iwait, iload          memory busy flag and read data
//   hit_count, miss_count hit cycles and fills started since reset
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, next_state;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  logic [31:0]      miss_addr;
  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             hit_c;
  logic             miss_start;
  logic             fill_en;

  // Byte-offset bits carry no information for word fetches.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^imemaddr[1:0];

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];
  assign hit_c    = imemREN && valid[idx] && (tags[idx] == tag);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and output decode
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'd0;
    iREN       = 1'b0;
    iaddr      = 32'd0;
    miss_start = 1'b0;
    fill_en    = 1'b0;
    case (state)
      IDLE: begin
        if (hit_c) begin
          ihit     = 1'b1;
          imemload = data[idx];
        end else if (imemREN) begin
          miss_start = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        // Fetch inputs are ignored here; a started fill always completes.
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Miss address, valid bits and statistics counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr  <= 32'd0;
      valid      <= '0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (miss_start) begin
        miss_addr  <= {imemaddr[31:2], 2'b00};
        miss_count <= miss_count + 32'd1;
      end
      if (ihit)    hit_count       <= hit_count + 32'd1;
      if (fill_en) valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: the driver pushes the expected outputs of
// each cycle into a queue; a monitor on the falling edge pops and compares.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'd0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard each cycle
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "ihit", 32'(ihit), 32'(e.hit));
      chk(e.name, "imemload", imemload, e.load);
      chk(e.name, "iREN", 32'(iREN), 32'(e.ren));
      chk(e.name, "iaddr", iaddr, e.addr);
      chk(e.name, "hit_count", hit_count, e.hc);
      chk(e.name, "miss_count", miss_count, e.mc);
    end
  end

  // One cycle of stimulus with its hand-computed expected outputs.
  // Counter expectations are the tallies before this cycle's events.
  task automatic cyc(input string nm, input logic ren, input logic [31:0] a,
                     input logic iw, input logic [31:0] ld,
                     input logic e_hit, input logic [31:0] e_load,
                     input logic e_ren, input logic [31:0] e_addr,
                     input logic is_miss);
    exp_t e;
    @(posedge CLK); #1;
    nRST = 1'b1;
    imemREN = ren; imemaddr = a; iwait = iw; iload = ld;
    e.name = nm; e.hit = e_hit; e.load = e_load; e.ren = e_ren; e.addr = e_addr;
    e.hc = 32'(exp_hits); e.mc = 32'(exp_misses);
    exp_q.push_back(e);
    if (e_hit) exp_hits++;
    if (is_miss) exp_misses++;
  endtask

  // Cycle spent in reset: everything must read zero, tallies restart.
  task automatic rst_cyc(input string nm, input logic [31:0] a);
    exp_t e;
    @(posedge CLK); #1;
    nRST = 1'b0;
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = 32'hDEADBEEF;
    e.name = nm; e.hit = 1'b0; e.load = 32'd0; e.ren = 1'b0; e.addr = 32'd0;
    e.hc = 32'd0; e.mc = 32'd0;
    exp_q.push_back(e);
    exp_hits = 0; exp_misses = 0;
  endtask

  localparam logic [31:0] W0  = 32'h3C010001;
  localparam logic [31:0] W40 = 32'hAAAA0040;
  localparam logic [31:0] W04 = 32'h11110004;
  localparam logic [31:0] W44 = 32'h22220044;
  localparam logic [31:0] W08 = 32'h55550008;

  initial begin
    rst_cyc("reset", 32'h0);

    // Cold miss on 0x0 with three busy cycles
    cyc("miss0", 1, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) cyc("fill0_wait", 1, 32'h0, 1, 32'h0, 0, 0, 1, 32'h0, 0);
    cyc("fill0_done", 1, 32'h0, 0, W0, 0, 0, 1, 32'h0, 0);
    cyc("hit0", 1, 32'h0, 1, 32'h0, 1, W0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) cyc("rehit0", 1, 32'h0, 1, 32'h0, 1, W0, 0, 32'h0, 0);
    cyc("idle_cnt6", 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0);

    // 0x40 evicts frame 0; 0x42 hits it; 0x0 then misses and refills
    cyc("miss40", 1, 32'h40, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc("fill40", 1, 32'h40, 0, W40, 0, 0, 1, 32'h40, 0);
    cyc("hit42", 1, 32'h42, 1, 32'h0, 1, W40, 0, 32'h0, 0);
    cyc("evict_miss0", 1, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc("refill0", 1, 32'h0, 0, W0, 0, 0, 1, 32'h0, 0);
    cyc("rehit0b", 1, 32'h0, 1, 32'h0, 1, W0, 0, 32'h0, 0);

    // Conflict thrash on frame 1
    for (int i = 0; i < 2; i++) begin
      cyc("miss04", 1, 32'h04, 1, 32'h0, 0, 0, 0, 32'h0, 1);
      cyc("fill04", 1, 32'h04, 0, W04, 0, 0, 1, 32'h04, 0);
      cyc("miss44", 1, 32'h44, 1, 32'h0, 0, 0, 0, 32'h0, 1);
      cyc("fill44", 1, 32'h44, 0, W44, 0, 0, 1, 32'h44, 0);
    end

    // Request withdrawn and address changed mid-fill
    cyc("miss08", 1, 32'h08, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc("fill08_hold", 0, 32'h0C, 1, 32'h0, 0, 0, 1, 32'h08, 0);
    cyc("fill08_hold", 0, 32'h0C, 1, 32'h0, 0, 0, 1, 32'h08, 0);
    cyc("fill08_done", 0, 32'h0C, 0, W08, 0, 0, 1, 32'h08, 0);
    cyc("noreq08", 0, 32'h08, 1, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc("hit08", 1, 32'h08, 1, 32'h0, 1, W08, 0, 32'h0, 0);
    cyc("hit44", 1, 32'h44, 1, 32'h0, 1, W44, 0, 32'h0, 0);

    // Reset in the middle of a fill
    cyc("miss10", 1, 32'h10, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc("fill10_wait", 1, 32'h10, 1, 32'h0, 0, 0, 1, 32'h10, 0);
    rst_cyc("reset_mid_fill", 32'h0);
    cyc("post_rst_miss0", 1, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc("post_rst_fill0", 1, 32'h0, 0, W0, 0, 0, 1, 32'h0, 0);
    cyc("post_rst_hit0", 1, 32'h0, 1, 32'h0, 1, W0, 0, 32'h0, 0);
    cyc("final_cnt", 0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's instruction-fetch port and the memory controller's instruction port. It serves fetches combinationally on a hit and raises `ihit`, which gates every pipeline latch and PC update in the datapath. On a miss it issues one word read to the memory controller, fills the frame, and then serves the fetch as a hit.

## Interface
- `SETS`, 16, number of one-word frames; power of two, minimum 2. `IDX_W = log2(SETS)`, `TAG_W = 30 - IDX_W`.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored.
- `ihit`  out  1  fetch served this cycle; `imemload` valid.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory read address, word-aligned.
- `iwait`  in  1  memory busy; read data valid in the cycle `iwait`=0 while `iREN`=1.
- `iload`  in  32  memory read data.
- `hit_count`  out  32  fetches served as hits since reset.
- `miss_count`  out  32  misses (fills started) since reset.

## Operation
- Address split: index = `imemaddr[IDX_W+1:2]`, tag = `imemaddr[31:IDX_W+2]`.
- Per frame: valid bit, TAG_W-bit tag, 32-bit data.
- FSM states: IDLE and FILL.
- IDLE:
  - hit = `imemREN` & valid[idx] & (tag[idx] == addr tag).
  - `ihit` = hit; `imemload` = data[idx] when hit, else 0.
  - `iREN` = 0; `iaddr` = 0.
  - `imemREN`=1 and no hit: latch `{imemaddr[31:2],2'b00}` into `miss_addr`, increment `miss_count`, go to FILL.
- FILL:
  - `iREN` = 1; `iaddr` = `miss_addr`; `ihit` = 0; `imemload` = 0.
  - When `iwait`=0: write frame[miss_addr idx] with valid=1, tag=miss_addr tag, data=`iload`, then return to IDLE.
  - `imemaddr` and `imemREN` are ignored while in FILL. A fill always completes once started; a request withdrawn mid-fill does not abort it.
- `hit_count` increments on every cycle with `ihit`=1. Both counters wrap at 2^32.
- Read-only: no write path and no dirty state. No invalidate input; frames clear only on reset.
- Reset mid-FILL: the fill is abandoned, the state returns to IDLE, and all frames become invalid.

## Timing
- Reset values:
  - `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
  - `hit_count`=0, `miss_count`=0.
  - All valid bits 0; state IDLE.
- Hit latency: 0 cycles. `ihit`/`imemload` are combinational from `imemaddr`, `imemREN` and the frame contents.
- Miss latency: 1 cycle (IDLE→FILL), then N cycles of `iwait`=1, then 1 fill cycle, then a hit on the following cycle in IDLE.
- With `iwait` deasserted immediately, a miss completes with `ihit` 2 cycles after the miss cycle. No same-cycle forwarding of `iload` to `imemload`.
- `iREN` and `iaddr` are held stable for the whole FILL state.
- Conflict: two addresses with the same index and different tags evict each other. Each alternate fetch misses.

## Test plan
- After reset, fetch 0x00000000 with `iwait` low after 3 cycles and `iload`=0x3C010001:
  - miss cycle: `ihit`=0, then `iREN`=1 with `iaddr`=0x0 for 4 cycles;
  - next cycle: `ihit`=1 with `imemload`=0x3C010001;
  - `miss_count`=1, `hit_count`=1.
- Refetch 0x00000000 for 5 cycles → `ihit`=1 every cycle, `iREN`=0, `hit_count`=6.
- Fetch 0x00000042 (bits [1:0]=2) after 0x40 is filled → hit on frame 0 data. Fill frame 0 at 0x40, then fetch 0x00000000 → miss (tag 1 vs 0), eviction, refill.
- Alternate 0x04 / 0x44 for 4 fetches with SETS=16 → 4 misses, 0 hits.
- During FILL for 0x08:
  - change `imemaddr` to 0x0C and drop `imemREN` → `iaddr` stays 0x08;
  - frame 2 is filled;
  - a later fetch of 0x08 hits with no memory access.
- Assert `nRST` low while in FILL with `iwait`=1 → all outputs 0 immediately; a fetch of any previously filled address then misses.
